// File: rtl/matmul_loader.sv
// Ping-pong frame loader for the matrix-multiply core: packs an 18-byte A|B
// stream into two buffers and replays each full frame as start pulse + bytes.
module matmul_loader #(
    parameter int N_ELEM = 18,
    parameter int DW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          mm_st,
    output logic [DW-1:0] mm_data,
    input  logic          mm_done,
    output logic          busy,
    output logic [7:0]    frame_cnt,
    output logic          err
);

    localparam int IW = $clog2(N_ELEM + 1);
    localparam logic [IW-1:0] LAST = IW'(N_ELEM - 1);
    localparam logic [IW-1:0] CNT  = IW'(N_ELEM);

    typedef enum logic [1:0] {S_IDLE, S_START, S_STREAM, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      full_q, full_d;
    logic            fsel_q, fsel_d;
    logic            ssel_q, ssel_d;
    logic [IW-1:0]   widx_q, widx_d;
    logic [IW-1:0]   ridx_q, ridx_d;
    logic            mm_st_q, mm_st_d;
    logic [DW-1:0]   mm_data_q, mm_data_d;
    logic            busy_q, busy_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic            err_q, err_d;
    logic            accept;

    logic [DW-1:0]   frame_mem [2][N_ELEM];

    assign in_ready = ~full_q[fsel_q];
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        full_d      = full_q;
        fsel_d      = fsel_q;
        ssel_d      = ssel_q;
        widx_d      = widx_q;
        ridx_d      = ridx_q;
        mm_st_d     = 1'b0;
        mm_data_d   = '0;
        busy_d      = busy_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;

        if (accept) begin
            if (widx_q == LAST) begin
                widx_d         = '0;
                fsel_d         = ~fsel_q;
                full_d[fsel_q] = 1'b1;
            end else begin
                widx_d = widx_q + 1'b1;
            end
        end

        // ridx counts bytes already presented, so the last byte leaves at CNT
        case (state_q)
            S_IDLE: begin
                if (full_q[ssel_q]) begin
                    state_d = S_START;
                    mm_st_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                state_d   = S_STREAM;
                mm_data_d = frame_mem[ssel_q][0];
                ridx_d    = IW'(1);
            end
            S_STREAM: begin
                if (ridx_q == CNT) begin
                    state_d = S_WAIT;
                end else begin
                    mm_data_d = frame_mem[ssel_q][ridx_q];
                    ridx_d    = ridx_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (mm_done) begin
                    full_d[ssel_q] = 1'b0;
                    ssel_d         = ~ssel_q;
                    frame_cnt_d    = frame_cnt_q + 8'd1;
                    busy_d         = 1'b0;
                    state_d        = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (mm_done && (state_q != S_WAIT)) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            full_q      <= '0;
            fsel_q      <= 1'b0;
            ssel_q      <= 1'b0;
            widx_q      <= '0;
            ridx_q      <= '0;
            mm_st_q     <= 1'b0;
            mm_data_q   <= '0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            fsel_q      <= fsel_d;
            ssel_q      <= ssel_d;
            widx_q      <= widx_d;
            ridx_q      <= ridx_d;
            mm_st_q     <= mm_st_d;
            mm_data_q   <= mm_data_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    // Frame storage is data only; reset just abandons whatever it holds
    always_ff @(posedge clk) begin
        if (accept) frame_mem[fsel_q][widx_q] <= in_data;
    end

    assign mm_st     = mm_st_q;
    assign mm_data   = mm_data_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_matmul_loader.sv
// Directed bench for matmul_loader: a negedge monitor checks every replayed
// frame against the bytes the driver got accepted, tests drive the scenarios.
module tb_matmul_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       mm_st;
    logic [7:0] mm_data;
    logic       mm_done = 1'b0;
    logic       busy;
    logic [7:0] frame_cnt;
    logic       err;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int st_cyc = 0;
    int st_cnt = 0;
    int mon_frames = 0;
    int last_cyc = 0;
    logic [7:0] exp_q[$];

    matmul_loader #(.N_ELEM(18), .DW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mm_st(mm_st), .mm_data(mm_data),
        .mm_done(mm_done), .busy(busy), .frame_cnt(frame_cnt), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", tag, act, exp_v, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            chk("send_timeout", 0, 1);
        end else begin
            exp_q.push_back(b);
            last_cyc = cyc;
            tick();
        end
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (mon_frames < target && n < 300) begin
            tick();
            n++;
        end
        chk("frame_wait", mon_frames, target);
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) tick();
    endtask

    task automatic ack();
        mm_done = 1'b1;
        tick();
        mm_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        exp_q.delete();
        rst = 1'b0;
    endtask

    // Monitor: on each start pulse, the next 18 cycles must carry the queued bytes
    initial begin
        forever begin
            @(negedge clk);
            if (mm_st === 1'b1 && rst === 1'b0) begin
                automatic bit aborted = 1'b0;
                st_cyc = cyc;
                st_cnt++;
                for (int k = 0; k < 18; k++) begin
                    @(negedge clk);
                    if (exp_q.size() == 0) chk("exp_avail", 0, 1);
                    else chk("mm_data", mm_data, exp_q.pop_front());
                    chk("st_low", mm_st, 0);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    @(negedge clk);
                    chk("data_idle", mm_data, 0);
                    mon_frames++;
                end
            end
        end
    end

    initial begin
        int c0;
        int base;
        int sc;
        int n;

        // Reset values
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mm_st", mm_st, 0);
        chk("rst_mm_data", mm_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // Single frame, done pulsed at C25
        for (int i = 1; i <= 18; i++) send_byte(8'(i));
        in_valid = 1'b0;
        c0 = last_cyc;
        chk("c1_busy", busy, 0);
        wait_frames(1);
        chk("st_cycle", st_cyc, c0 + 2);
        wait_cycle(c0 + 25);
        chk("c25_busy", busy, 1);
        ack();
        chk("c26_busy", busy, 0);
        chk("single_cnt", frame_cnt, 1);
        chk("single_err", err, 0);

        // Back-pressure: 36 bytes, done held low
        base = mon_frames;
        for (int i = 1; i <= 36; i++) send_byte(8'(i));
        chk("bp_ready_low", in_ready, 0);
        in_data = 8'd37;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_stall", in_ready, 0);
        end
        in_valid = 1'b0;
        wait_frames(base + 1);
        chk("bp_ready_wait", in_ready, 0);
        ack();
        chk("bp_ready_rise", in_ready, 1);
        chk("bp_cnt1", frame_cnt, 2);
        tick();
        chk("bp_st_d2", mm_st, 1);
        wait_frames(base + 2);
        ack();
        chk("bp_cnt2", frame_cnt, 3);

        // Throttled input, valid toggling every cycle
        base = mon_frames;
        for (int i = 0; i < 18; i++) begin
            send_byte(8'hA0 + 8'(i));
            in_valid = 1'b0;
            tick();
        end
        wait_frames(base + 1);
        ack();
        chk("thr_cnt", frame_cnt, 4);

        // Premature done during STREAM
        base = mon_frames;
        sc = st_cnt;
        for (int i = 0; i < 18; i++) send_byte(8'h40 + 8'(i));
        in_valid = 1'b0;
        n = 0;
        while (st_cnt == sc && n < 100) begin
            tick();
            n++;
        end
        chk("pre_st_seen", st_cnt, sc + 1);
        tick();
        tick();
        ack();
        chk("pre_err", err, 1);
        chk("pre_busy", busy, 1);
        chk("pre_cnt_hold", frame_cnt, 4);
        wait_frames(base + 1);
        tick();
        tick();
        chk("pre_wait_busy", busy, 1);
        chk("pre_err_sticky", err, 1);
        ack();
        chk("pre_cnt", frame_cnt, 5);
        chk("pre_err_after", err, 1);

        // Reset mid-stream at C10
        for (int i = 0; i < 18; i++) send_byte(8'h60 + 8'(i));
        in_valid = 1'b0;
        c0 = last_cyc;
        wait_cycle(c0 + 10);
        chk("c10_busy", busy, 1);
        do_reset();
        chk("mrst_mm_data", mm_data, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_cnt", frame_cnt, 0);
        chk("mrst_err", err, 0);
        base = mon_frames;
        for (int i = 0; i < 18; i++) send_byte(8'h70 + 8'(i));
        in_valid = 1'b0;
        wait_frames(base + 1);
        ack();
        chk("mrst_fresh_cnt", frame_cnt, 1);

        // Counter wrap over 256 acknowledged frames
        do_reset();
        for (int j = 0; j < 256; j++) begin
            base = mon_frames;
            for (int i = 0; i < 18; i++) send_byte(8'(j + i * 7));
            in_valid = 1'b0;
            wait_frames(base + 1);
            ack();
            chk("wrap_cnt", frame_cnt, 32'((j + 1) & 255));
        end
        chk("wrap_err", err, 0);
        chk("wrap_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
